// File: rtl/word_to_byte_reader.sv
// Byte-granular read adapter in front of a 32-bit word memory, with a one-word
// buffer that serves repeat reads of the same word without another fetch.
module word_to_byte_reader #(
  parameter int BYTE_ADDR_WIDTH = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [BYTE_ADDR_WIDTH-1:0] req_addr,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [7:0]                 rsp_data,
  output logic                       mem_rd_en,
  output logic [BYTE_ADDR_WIDTH-3:0] mem_addr,
  input  logic [31:0]                mem_rd_data,
  input  logic                       snoop_wr_en,
  input  logic [BYTE_ADDR_WIDTH-3:0] snoop_word_addr,
  input  logic                       flush
);

  // state   | meaning
  // IDLE    | ready for a byte request
  // FETCH   | word read strobe to memory
  // CAPTURE | memory data valid, fill buffer and pick the lane
  // RESP    | byte presented, waiting for rsp_ready
  typedef enum logic [1:0] {IDLE, FETCH, CAPTURE, RESP} state_t;

  state_t                     state;
  logic                       buf_valid;
  logic                       fetch_clean;
  logic [31:0]                buf_word;
  logic [BYTE_ADDR_WIDTH-3:0] tag;
  logic [1:0]                 offset;
  logic [7:0]                 rsp_data_q;

  logic in_flight;
  logic snoop_hit;
  logic inv;
  logic hit;

  function automatic logic [7:0] lane(input logic [31:0] w, input logic [1:0] o);
    logic [7:0] b;
    case (o)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

  assign in_flight = (state == FETCH) || (state == CAPTURE);
  assign snoop_hit = snoop_wr_en && (snoop_word_addr == tag);
  assign inv       = flush || (snoop_hit && (buf_valid || in_flight));
  assign hit       = buf_valid && (req_addr[BYTE_ADDR_WIDTH-1:2] == tag) && !inv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      buf_valid   <= 1'b0;
      fetch_clean <= 1'b0;
      buf_word    <= '0;
      tag         <= '0;
      offset      <= '0;
      rsp_data_q  <= '0;
    end else begin
      if (inv) buf_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            tag    <= req_addr[BYTE_ADDR_WIDTH-1:2];
            offset <= req_addr[1:0];
            if (hit) begin
              rsp_data_q <= lane(buf_word, req_addr[1:0]);
              state      <= RESP;
            end else begin
              // the buffer is about to be overwritten, so it no longer matches tag
              buf_valid   <= 1'b0;
              fetch_clean <= 1'b1;
              state       <= FETCH;
            end
          end
        end
        FETCH: begin
          if (inv) fetch_clean <= 1'b0;
          state <= CAPTURE;
        end
        CAPTURE: begin
          buf_word   <= mem_rd_data;
          rsp_data_q <= lane(mem_rd_data, offset);
          buf_valid  <= fetch_clean && !inv;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign mem_rd_en = (state == FETCH);
  assign mem_addr  = (state == FETCH) ? tag : '0;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_word_to_byte_reader.sv
// Bench for word_to_byte_reader: directed scenarios plus randomized reads
// against a buffer/memory reference model.
module tb_word_to_byte_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [5:0]  req_addr = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [7:0]  rsp_data;
  logic        mem_rd_en;
  logic [3:0]  mem_addr;
  logic [31:0] mem_rd_data = '0;
  logic        snoop_wr_en = 1'b0;
  logic [3:0]  snoop_word_addr = '0;
  logic [31:0] snoop_data = '0;
  logic        flush = 1'b0;

  int checks = 0;
  int failures = 0;

  logic [31:0] tb_mem [16];
  int          rd_total = 0;
  bit          mdl_valid = 1'b0;
  logic [3:0]  mdl_tag = '0;

  always #5 clk = ~clk;

  word_to_byte_reader #(.BYTE_ADDR_WIDTH(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .snoop_wr_en(snoop_wr_en), .snoop_word_addr(snoop_word_addr), .flush(flush)
  );

  // synchronous memory; writes arrive through the snoop port
  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_rd_data <= tb_mem[mem_addr];
      rd_total    <= rd_total + 1;
    end
    if (snoop_wr_en) tb_mem[snoop_word_addr] <= snoop_data;
  end

  task automatic mem_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    snoop_wr_en = 1'b1; snoop_word_addr = a; snoop_data = d;
    @(posedge clk); #1;
    snoop_wr_en = 1'b0;
    if (mdl_valid && a == mdl_tag) mdl_valid = 1'b0;
  endtask

  task automatic do_flush();
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    mdl_valid = 1'b0;
  endtask

  task automatic do_read(input logic [5:0] addr, input int hold, input int flush_at, input string name);
    logic [3:0] w;
    int         ln, lat, rds, exp_lat;
    bit         exp_hit, flushed;
    logic [7:0] exp_byte;
    w = addr[5:2];
    ln = int'(addr[1:0]);
    exp_byte = tb_mem[w][8*ln +: 8];
    exp_hit = mdl_valid && (mdl_tag == w);
    exp_lat = exp_hit ? 1 : 3;
    flushed = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      failures++; $display("FAIL %s req_ready_idle got=%b exp=1", name, req_ready);
    end
    req_valid = 1'b1; req_addr = addr;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1; rds = 0;
    while (rsp_valid !== 1'b1 && lat < 10) begin
      if (mem_rd_en === 1'b1) begin
        rds++;
        checks++;
        if (mem_addr !== w) begin
          failures++; $display("FAIL %s mem_addr got=%0d exp=%0d", name, mem_addr, w);
        end
      end
      flush = (lat == flush_at);
      if (lat == flush_at) flushed = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      lat++;
    end
    checks++;
    if (lat !== exp_lat || rsp_valid !== 1'b1) begin
      failures++; $display("FAIL %s latency got=%0d exp=%0d (rsp_valid=%b)", name, lat, exp_lat, rsp_valid);
    end
    checks++;
    if (rds !== (exp_hit ? 0 : 1)) begin
      failures++; $display("FAIL %s mem_reads got=%0d exp=%0d", name, rds, exp_hit ? 0 : 1);
    end
    checks++;
    if (rsp_data !== exp_byte) begin
      failures++; $display("FAIL %s rsp_data got=%h exp=%h", name, rsp_data, exp_byte);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== exp_byte || req_ready !== 1'b0 || mem_rd_en !== 1'b0) begin
        failures++;
        $display("FAIL %s hold%0d got valid=%b data=%h rdy=%b rd=%b exp valid=1 data=%h rdy=0 rd=0",
                 name, i, rsp_valid, rsp_data, req_ready, mem_rd_en, exp_byte);
      end
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++; $display("FAIL %s release got valid=%b rdy=%b exp valid=0 rdy=1", name, rsp_valid, req_ready);
    end
    mdl_valid = !flushed;
    mdl_tag = w;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_data !== 8'h00 || mem_rd_en !== 1'b0 || mem_addr !== 4'd0) begin
      failures++;
      $display("FAIL reset got rdy=%b valid=%b data=%h rd=%b addr=%0d exp 1 0 00 0 0",
               req_ready, rsp_valid, rsp_data, mem_rd_en, mem_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mdl_valid = 1'b0;
    for (int i = 0; i < 16; i++) mem_write(4'(i), $urandom);
    mem_write(4'd1, 32'hDDCCBBAA);
  endtask

  task automatic test_basic_miss();
    do_read(6'h05, 0, 0, "basic_miss");
  endtask

  task automatic test_same_word();
    int start;
    do_flush();
    start = rd_total;
    do_read(6'h04, 0, 0, "same_w0");
    do_read(6'h05, 0, 0, "same_w1");
    do_read(6'h06, 0, 0, "same_w2");
    do_read(6'h07, 0, 0, "same_w3");
    checks++;
    if (rd_total - start !== 1) begin
      failures++; $display("FAIL same_word_fetches got=%0d exp=1", rd_total - start);
    end
  endtask

  task automatic test_back_pressure();
    do_read(6'h06, 5, 0, "back_pressure");
  endtask

  task automatic test_snoop();
    mem_write(4'd2, 32'h5566_7788);
    do_read(6'h05, 0, 0, "snoop_other_hit");
    mem_write(4'd1, 32'h1122_3344);
    do_read(6'h04, 0, 0, "snoop_refetch");
  endtask

  task automatic test_flush_capture();
    do_read(6'h09, 0, 2, "flush_capture");
    do_read(6'h0A, 0, 0, "flush_reread");
  endtask

  task automatic test_reset_mid();
    int n;
    do_read(6'h0D, 0, 0, "pre_reset");
    @(negedge clk);
    req_valid = 1'b1; req_addr = 6'h0E;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 10) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (rsp_valid !== 1'b1) begin
      failures++; $display("FAIL reset_mid_resp got valid=%b exp=1", rsp_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || mem_rd_en !== 1'b0) begin
      failures++; $display("FAIL reset_mid got valid=%b rdy=%b rd=%b exp 0 1 0", rsp_valid, req_ready, mem_rd_en);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mdl_valid = 1'b0;
    do_read(6'h0F, 0, 0, "post_reset_miss");
  endtask

  task automatic test_random();
    logic [5:0] a;
    int ev;
    for (int i = 0; i < 60; i++) begin
      ev = int'($urandom_range(0, 4));
      if (ev == 1) do_flush();
      else if (ev == 2) mem_write(4'($urandom_range(0, 15)), $urandom);
      else if (ev == 3) mem_write(mdl_tag, $urandom);
      if ($urandom_range(0, 1) == 1) a = {mdl_tag, 2'($urandom_range(0, 3))};
      else a = 6'($urandom_range(0, 63));
      do_read(a, int'($urandom_range(0, 2)), 0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic_miss();
    test_same_word();
    test_back_pressure();
    test_snoop();
    test_flush_capture();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
